// File: rtl/mmio_responder.sv
// mmio_responder: 8-word MMIO window on the CPU data port with a reloadable interval
// timer and a FIFO-buffered 8N1 UART transmitter; all state advances on clk_en ticks.
module mmio_responder #(
    parameter logic [17:0] BASE       = 18'h3FF00,
    parameter int          FIFO_DEPTH = 16,
    parameter int          BAUD_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        mem_re,
    input  logic [17:0] mem_read1_addr,
    input  logic [3:0]  mem_we,
    input  logic [17:0] mem_write_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mmio_read_data,
    output logic        mmio_hit,
    output logic [15:0] interrupts,
    output logic        uart_txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1'b1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1'b1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} tx_state_e;

    logic [31:0] count_q, count_d, reload_q, reload_d, rdata_q, rdata_d, rd_val_s;
    logic [2:0]  ctrl_q, ctrl_d, bit_q, bit_d;
    logic        pend_q, pend_d, ovf_q, ovf_d, hit_q, hit_d, txd_q, txd_d;
    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [7:0]  fifo_d [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, fifo_cnt_s;
    logic [7:0]  shift_q, shift_d, fifo_cnt8_s;
    logic [BW-1:0] baud_q, baud_d;
    tx_state_e   state_q, state_d;

    logic rd_hit_s, wr_hit_s, fifo_full_s, fifo_empty_s, tx_busy_s, tx_irq_s, baud_done_s, pop_s;
    logic we_reload_s, we_ctrl_s, irq_clr_s, push_s, ovf_clr_s;
    logic timer_tick_s, timer_start_s, timer_wrap_s;
    logic [2:0] rd_off_s, wr_off_s;

    assign rd_hit_s     = mem_re & (mem_read1_addr[17:3] == BASE[17:3]);
    assign wr_hit_s     = (mem_write_addr[17:3] == BASE[17:3]);
    assign rd_off_s     = mem_read1_addr[2:0];
    assign wr_off_s     = mem_write_addr[2:0];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fifo_empty_s = (wptr_q == rptr_q);
    assign fifo_cnt_s   = wptr_q - rptr_q;
    assign fifo_cnt8_s  = 8'(fifo_cnt_s);
    assign tx_busy_s    = (state_q != S_IDLE);
    assign tx_irq_s     = ctrl_q[2] & fifo_empty_s & ~tx_busy_s;
    assign baud_done_s  = (baud_q == BAUD_LAST);
    assign timer_tick_s  = clk_en & ctrl_q[0];
    assign timer_start_s = we_ctrl_s & ~ctrl_q[0] & mem_write_data[0];
    assign timer_wrap_s  = timer_tick_s & (count_q == 32'd1);

    assign mmio_read_data = rdata_q;
    assign mmio_hit       = hit_q;
    assign interrupts     = {14'd0, tx_irq_s, pend_q};
    assign uart_txd       = txd_q;

    // Write decode: one strobe per register action, gated by the tick.
    always_comb begin
        we_reload_s = 1'b0;
        we_ctrl_s   = 1'b0;
        irq_clr_s   = 1'b0;
        push_s      = 1'b0;
        ovf_clr_s   = 1'b0;
        if (clk_en && wr_hit_s) begin
            case (wr_off_s)
                3'd1:    we_reload_s = 1'b1;
                3'd2:    we_ctrl_s   = mem_we[0];
                3'd3:    irq_clr_s   = mem_we[0] & mem_write_data[0];
                3'd4:    push_s      = mem_we[0];
                3'd5:    ovf_clr_s   = mem_we[0] & mem_write_data[2];
                default: we_reload_s = 1'b0;
            endcase
        end else begin
            we_reload_s = 1'b0;
        end
    end

    // Read mux and the one-tick registered response.
    always_comb begin
        rd_val_s = 32'd0;
        case (rd_off_s)
            3'd0:    rd_val_s = count_q;
            3'd1:    rd_val_s = reload_q;
            3'd2:    rd_val_s = {29'd0, ctrl_q};
            3'd3:    rd_val_s = {30'd0, tx_irq_s, pend_q};
            3'd5:    rd_val_s = {16'd0, fifo_cnt8_s, 4'd0, tx_busy_s, ovf_q, fifo_empty_s, fifo_full_s};
            default: rd_val_s = 32'd0;
        endcase
        rdata_d = rdata_q;
        hit_d   = hit_q;
        if (clk_en) begin
            rdata_d = rd_hit_s ? rd_val_s : 32'd0;
            hit_d   = rd_hit_s;
        end else begin
            rdata_d = rdata_q;
            hit_d   = hit_q;
        end
    end

    // Timer, RELOAD/CTRL byte-lane writes; an enabling CTRL write outranks a wrap.
    always_comb begin
        reload_d = reload_q;
        for (int i = 0; i < 4; i++) begin
            if (we_reload_s && mem_we[i]) reload_d[8*i +: 8] = mem_write_data[8*i +: 8];
            else                          reload_d[8*i +: 8] = reload_q[8*i +: 8];
        end
        ctrl_d = we_ctrl_s ? mem_write_data[2:0] : ctrl_q;
        if (timer_start_s)                           count_d = reload_q;
        else if (timer_wrap_s)                       count_d = reload_q;
        else if (timer_tick_s && count_q != 32'd0)   count_d = count_q - 32'd1;
        else                                         count_d = count_q;
        pend_d = timer_wrap_s | (pend_q & ~irq_clr_s);
    end

    // TX framing FSM; uart_en is only sampled between frames.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        pop_s   = 1'b0;
        if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_q[1] && !fifo_empty_s) begin
                        state_d = S_START;
                        pop_s   = 1'b1;
                        shift_d = fifo_q[rptr_q[AW-1:0]];
                        baud_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (baud_done_s) begin
                        state_d = S_DATA;
                        baud_d  = '0;
                        bit_d   = 3'd0;
                    end else begin
                        baud_d = baud_q + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (baud_done_s) begin
                        baud_d  = '0;
                        shift_d = {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) state_d = S_STOP;
                        else               bit_d   = bit_q + 3'd1;
                    end else begin
                        baud_d = baud_q + BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (baud_done_s) begin
                        baud_d = '0;
                        if (ctrl_q[1] && !fifo_empty_s) begin
                            state_d = S_START;
                            pop_s   = 1'b1;
                            shift_d = fifo_q[rptr_q[AW-1:0]];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        baud_d = baud_q + BAUD_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // FIFO storage and sticky overflow; a push into a full FIFO is dropped.
    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        if (push_s && !fifo_full_s) begin
            fifo_d[wptr_q[AW-1:0]] = mem_write_data[7:0];
            wptr_d                 = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        rptr_d = pop_s ? (rptr_q + PTR_ONE) : rptr_q;
        ovf_d  = (push_s & fifo_full_s) | (ovf_q & ~ovf_clr_s);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 32'd0;
            reload_q <= 32'd0;
            ctrl_q   <= 3'd0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'h00;
            state_q  <= S_IDLE;
            shift_q  <= 8'h00;
            bit_q    <= 3'd0;
            baud_q   <= '0;
            txd_q    <= 1'b1;
            rdata_q  <= 32'd0;
            hit_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            ctrl_q   <= ctrl_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fifo_q   <= fifo_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            txd_q    <= txd_d;
            rdata_q  <= rdata_d;
            hit_q    <= hit_d;
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios plus randomized traffic, all checked
// against a transaction-level model (queues for FIFO contents and the serial waveform).
module tb_mmio_responder;
    localparam logic [17:0] BASE  = 18'h3FF00;
    localparam int          DEPTH = 16;
    localparam int          BD    = 4;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, mem_re;
    logic [17:0] mem_read1_addr, mem_write_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_write_data;
    logic [31:0] mmio_read_data;
    logic        mmio_hit, uart_txd;
    logic [15:0] interrupts;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_count, m_reload, e_rdata;
    logic [2:0]  m_ctrl;
    logic        m_pend, m_ovf, e_hit;
    logic [7:0]  m_fifo[$];
    logic        m_wave[$];

    mmio_responder #(.BASE(BASE), .FIFO_DEPTH(DEPTH), .BAUD_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mem_re(mem_re),
        .mem_read1_addr(mem_read1_addr), .mem_we(mem_we), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mmio_read_data(mmio_read_data), .mmio_hit(mmio_hit),
        .interrupts(interrupts), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] adr(input logic [2:0] off);
        return {BASE[17:3], off};
    endfunction

    function automatic logic m_irq1();
        return m_ctrl[2] && (m_fifo.size() == 0) && (m_wave.size() == 0);
    endfunction

    function automatic logic [15:0] e_irq();
        return {14'd0, m_irq1(), m_pend};
    endfunction

    function automatic logic e_txd();
        return (m_wave.size() != 0) ? m_wave[0] : 1'b1;
    endfunction

    function automatic logic [31:0] m_reg(input logic [2:0] off);
        case (off)
            3'd0:    return m_count;
            3'd1:    return m_reload;
            3'd2:    return {29'd0, m_ctrl};
            3'd3:    return {30'd0, m_irq1(), m_pend};
            3'd5:    return {16'd0, 8'(m_fifo.size()), 4'd0, (m_wave.size() != 0), m_ovf,
                             (m_fifo.size() == 0), (m_fifo.size() == DEPTH)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 32'd0; m_reload = 32'd0; m_ctrl = 3'd0; m_pend = 1'b0; m_ovf = 1'b0;
        e_rdata = 32'd0; e_hit = 1'b0;
        m_fifo.delete();
        m_wave.delete();
    endtask

    // Drive one tick, advance the model by the spec rules, sample #1 after the edge.
    task automatic step(input logic en, input logic re, input logic [17:0] ra,
                        input logic [3:0] wen, input logic [17:0] wa, input logic [31:0] wd);
        logic rhit, whit, tset, oset, b;
        logic [2:0] wo, old_ctrl;
        logic [31:0] old_reload;
        logic [7:0] byte_v;
        int old_size;
        clk_en = en; mem_re = re; mem_read1_addr = ra;
        mem_we = wen; mem_write_addr = wa; mem_write_data = wd;
        if (en) begin
            rhit = re && (ra[17:3] == BASE[17:3]);
            e_rdata = rhit ? m_reg(ra[2:0]) : 32'd0;
            e_hit = rhit;
            whit = (wa[17:3] == BASE[17:3]);
            wo = wa[2:0];
            old_ctrl = m_ctrl; old_reload = m_reload; old_size = m_fifo.size();
            tset = 1'b0; oset = 1'b0;
            if (whit && wo == 3'd2 && wen[0] && !old_ctrl[0] && wd[0]) m_count = old_reload;
            else if (old_ctrl[0] && m_count == 32'd1) begin m_count = old_reload; tset = 1'b1; end
            else if (old_ctrl[0] && m_count != 32'd0) m_count = m_count - 32'd1;
            if (whit && wo == 3'd3 && wen[0] && wd[0]) m_pend = 1'b0;
            if (tset) m_pend = 1'b1;
            for (int i = 0; i < 4; i++)
                if (whit && wo == 3'd1 && wen[i]) m_reload[8*i +: 8] = wd[8*i +: 8];
            if (whit && wo == 3'd2 && wen[0]) m_ctrl = wd[2:0];
            if (m_wave.size() != 0) b = m_wave.pop_front();
            if (m_wave.size() == 0 && old_ctrl[1] && old_size != 0) begin
                byte_v = m_fifo.pop_front();
                repeat (BD) m_wave.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (BD) m_wave.push_back(byte_v[i]);
                repeat (BD) m_wave.push_back(1'b1);
            end
            if (whit && wo == 3'd4 && wen[0]) begin
                if (old_size == DEPTH) oset = 1'b1;
                else m_fifo.push_back(wd[7:0]);
            end
            if (whit && wo == 3'd5 && wen[0] && wd[2]) m_ovf = 1'b0;
            if (oset) m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [3:0] wen, input logic [31:0] wd);
        step(1'b1, 1'b0, 18'd0, wen, adr(off), wd);
    endtask

    task automatic rd(input logic [2:0] off);
        step(1'b1, 1'b1, adr(off), 4'd0, 18'd0, 32'd0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 18'd0, 4'd0, 18'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b0; mem_re = 1'b0; mem_we = 4'd0;
        mem_read1_addr = 18'd0; mem_write_addr = 18'd0; mem_write_data = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (mmio_read_data !== 32'd0 || mmio_hit !== 1'b0) begin
            n_err++; $display("FAIL reset_read: got data=%h hit=%b, want 0/0", mmio_read_data, mmio_hit);
        end
        n_vec++;
        if (interrupts !== 16'd0 || uart_txd !== 1'b1) begin
            n_err++; $display("FAIL reset_out: got irq=%h txd=%b, want 0/1", interrupts, uart_txd);
        end
        rst_n = 1'b1;
        wr(3'd1, 4'hF, 32'd2);
        wr(3'd2, 4'hF, 32'd7);
        wr(3'd4, 4'h1, 32'h00);
        repeat (12) idle();
        n_vec++;
        if (uart_txd !== e_txd() || interrupts !== e_irq()) begin
            n_err++; $display("FAIL midframe: got txd=%b irq=%h, want %b/%h", uart_txd, interrupts, e_txd(), e_irq());
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (uart_txd !== 1'b1 || interrupts !== 16'd0) begin
            n_err++; $display("FAIL async_reset: got txd=%b irq=%h, want 1/0", uart_txd, interrupts);
        end
        n_vec++;
        if (mmio_read_data !== 32'd0 || mmio_hit !== 1'b0) begin
            n_err++; $display("FAIL async_reset_rd: got %h/%b, want 0/0", mmio_read_data, mmio_hit);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(3'd1);
        n_vec++;
        if (mmio_read_data !== 32'd0 || mmio_hit !== 1'b1) begin
            n_err++; $display("FAIL post_reset_read: got %h/%b, want 0/1", mmio_read_data, mmio_hit);
        end
    endtask

    task automatic test_timer();
        logic [31:0] exp_cnt [4];
        logic prev;
        int rise1, rise2;
        exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd3};
        rise1 = -1; rise2 = -1;
        wr(3'd1, 4'hF, 32'd3);
        wr(3'd2, 4'h1, 32'd1);
        prev = interrupts[0];
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) wr(3'd3, 4'h1, 32'd1);
            else        rd(3'd0);
            if (k <= 4) begin
                n_vec++;
                if (mmio_read_data !== exp_cnt[k-1]) begin
                    n_err++; $display("FAIL timer_count k=%0d: got %0d, want %0d", k, mmio_read_data, exp_cnt[k-1]);
                end
            end
            n_vec++;
            if (interrupts !== e_irq() || (k != 5 && mmio_read_data !== e_rdata)) begin
                n_err++; $display("FAIL timer_model k=%0d: got irq=%h rd=%h, want %h/%h", k, interrupts, mmio_read_data, e_irq(), e_rdata);
            end
            if (interrupts[0] && !prev) begin
                if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
            end
            prev = interrupts[0];
        end
        n_vec++;
        if (rise1 != 3 || rise2 != 6) begin
            n_err++; $display("FAIL timer_period: got rises at %0d,%0d, want 3,6", rise1, rise2);
        end
        wr(3'd2, 4'h1, 32'd0);
        wr(3'd3, 4'h1, 32'd1);
    endtask

    task automatic test_uart_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        wr(3'd2, 4'h1, 32'd2);
        wr(3'd4, 4'h1, 32'hA5);
        for (int j = 0; j < 10 * BD; j++) begin
            idle();
            n_vec++;
            if (uart_txd !== frame[j / BD]) begin
                n_err++; $display("FAIL frame_bit j=%0d: got %b, want %b", j, uart_txd, frame[j / BD]);
            end
        end
        idle();
        rd(3'd5);
        n_vec++;
        if ((mmio_read_data & 32'h0000000A) !== 32'h00000002 || mmio_read_data !== e_rdata) begin
            n_err++; $display("FAIL frame_status: got %h, want %h", mmio_read_data, e_rdata);
        end
    endtask

    task automatic test_overflow();
        wr(3'd2, 4'h1, 32'd0);
        for (int i = 0; i < DEPTH + 1; i++) wr(3'd4, 4'h1, 32'($urandom_range(0, 255)));
        rd(3'd5);
        n_vec++;
        if ((mmio_read_data & 32'h0000FF05) !== 32'h00001005 || mmio_read_data !== e_rdata) begin
            n_err++; $display("FAIL ovf_status: got %h, want %h", mmio_read_data, e_rdata);
        end
        wr(3'd2, 4'h1, 32'd2);
        for (int j = 0; j < DEPTH * 10 * BD + 8; j++) begin
            idle();
            n_vec++;
            if (uart_txd !== e_txd()) begin
                n_err++; $display("FAIL ovf_txd j=%0d: got %b, want %b", j, uart_txd, e_txd());
            end
        end
        rd(3'd5);
        n_vec++;
        if (mmio_read_data !== 32'h00000006) begin
            n_err++; $display("FAIL ovf_drained: got %h, want 00000006", mmio_read_data);
        end
        wr(3'd5, 4'h1, 32'd4);
        rd(3'd5);
        n_vec++;
        if (mmio_read_data !== 32'h00000002) begin
            n_err++; $display("FAIL ovf_clear: got %h, want 00000002", mmio_read_data);
        end
    endtask

    task automatic test_byte_lanes();
        wr(3'd2, 4'h1, 32'd0);
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd1, 4'b0011, 32'hFFFFFFFF);
        rd(3'd1);
        n_vec++;
        if (mmio_read_data !== 32'h0000FFFF) begin
            n_err++; $display("FAIL lane_reload: got %h, want 0000ffff", mmio_read_data);
        end
        wr(3'd4, 4'b1110, 32'h12345678);
        rd(3'd5);
        n_vec++;
        if ((mmio_read_data & 32'h0000FF02) !== 32'h00000002) begin
            n_err++; $display("FAIL lane_push: got status %h, want empty with count 0", mmio_read_data);
        end
    endtask

    task automatic test_collisions();
        wr(3'd2, 4'h1, 32'd0);
        wr(3'd1, 4'hF, 32'd2);
        wr(3'd2, 4'h1, 32'd1);
        for (int k = 0; k < 8 && !(m_ctrl[0] && m_count == 32'd1); k++) idle();
        wr(3'd3, 4'h1, 32'd1);
        n_vec++;
        if (interrupts[0] !== 1'b1) begin
            n_err++; $display("FAIL set_vs_w1c: got %b, want 1", interrupts[0]);
        end
        wr(3'd2, 4'h1, 32'd0);
        wr(3'd3, 4'h1, 32'd1);
        wr(3'd2, 4'h1, 32'd1);
        n_vec++;
        if (interrupts[0] !== 1'b0) begin
            n_err++; $display("FAIL load_vs_wrap: got pending %b, want 0", interrupts[0]);
        end
        rd(3'd0);
        n_vec++;
        if (mmio_read_data !== 32'd2 || mmio_read_data !== e_rdata) begin
            n_err++; $display("FAIL load_count: got %0d, want 2", mmio_read_data);
        end
        wr(3'd2, 4'h1, 32'd4);
        wr(3'd3, 4'h1, 32'd1);
        n_vec++;
        if (interrupts[1] !== 1'b1) begin
            n_err++; $display("FAIL tx_irq_level: got %b, want 1", interrupts[1]);
        end
        wr(3'd4, 4'h1, 32'h55);
        n_vec++;
        if (interrupts[1] !== 1'b0) begin
            n_err++; $display("FAIL tx_irq_push: got %b, want 0", interrupts[1]);
        end
    endtask

    task automatic test_random();
        logic en, re;
        logic [17:0] ra, wa;
        logic [3:0] wen;
        logic [31:0] wd;
        for (int k = 0; k < 2000; k++) begin
            en  = ($urandom_range(0, 3) != 0);
            re  = ($urandom_range(0, 1) == 1);
            ra  = ($urandom_range(0, 7) == 0) ? 18'($urandom) : adr(3'($urandom_range(0, 7)));
            wen = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            wa  = ($urandom_range(0, 7) == 0) ? 18'($urandom) : adr(3'($urandom_range(0, 7)));
            wd  = $urandom;
            if (wa[2:0] == 3'd1) wd = 32'($urandom_range(0, 6));
            step(en, re, ra, wen, wa, wd);
            n_vec++;
            if (mmio_read_data !== e_rdata || mmio_hit !== e_hit) begin
                n_err++; $display("FAIL rand_read k=%0d: got %h/%b, want %h/%b", k, mmio_read_data, mmio_hit, e_rdata, e_hit);
            end
            n_vec++;
            if (interrupts !== e_irq()) begin
                n_err++; $display("FAIL rand_irq k=%0d: got %h, want %h", k, interrupts, e_irq());
            end
            n_vec++;
            if (uart_txd !== e_txd()) begin
                n_err++; $display("FAIL rand_txd k=%0d: got %b, want %b", k, uart_txd, e_txd());
            end
        end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_uart_frame();
        test_overflow();
        test_byte_lanes();
        test_collisions();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
